// File: rtl/core_pkg.sv
// Shared definitions for the synapse32 core: instruction width, NOP
// encoding, default reset PC and the fetch queue entry layout.
package core_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry FIFO of fetch entries with push, pop and flush.
// Flush wins over push and pop; the head is read straight from storage.
module fetch_queue
  import core_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PTR_W = $clog2(DEPTH),
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  fetch_entry_t     data_i,
  output fetch_entry_t     head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o,
  output logic             full_o
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Pushing into a full queue is only legal when the head leaves this cycle.
  assign do_push = push_i & ~flush_i & (~full_o | pop_i);
  assign do_pop  = pop_i & ~flush_i & ~empty_o;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, instruction memory addressing,
// fetch queue towards decode and redirect handling.
// Optional FETCH_MISALIGN_CHECK_EN: misaligned redirects set a sticky error and halt fetch.
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_en_i,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic [INSTR_W-1:0] imem_data_i,
  input  logic               redirect_valid_i,
  input  logic [31:0]        redirect_pc_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [31:0]        out_pc_o,
  output logic [INSTR_W-1:0] out_instr_o,
  output logic [31:0]        pc_o,
  output logic               misalign_err_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [31:0]      pc_q, pc_d;
  logic             halted;
  logic             push, pop;
  logic             q_empty, q_full;
  logic [CNT_W-1:0] q_count_unused;
  fetch_entry_t     q_in, q_head;

  assign imem_addr_o = pc_q[ADDR_W+1:2];
  assign pc_o        = pc_q;

  assign out_valid_o = ~q_empty;
  assign out_pc_o    = q_head.pc;
  assign out_instr_o = q_head.instr;

  assign pop  = out_valid_o & out_ready_i;
  assign push = fetch_en_i & ~redirect_valid_i & ~halted & (~q_full | pop);

  assign q_in.pc    = pc_q;
  assign q_in.instr = imem_data_i;

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid_i) pc_d = {redirect_pc_i[31:2], 2'b00};
    else if (push)        pc_d = pc_q + 32'd4;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  always_comb begin
    misalign_d = misalign_q;
    if (redirect_valid_i && (redirect_pc_i[1:0] != 2'b00)) misalign_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= misalign_d;
  end

  assign halted         = misalign_q;
  assign misalign_err_o = misalign_q;
`else
  // Low target bits are don't-care when the check is compiled out.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = |redirect_pc_i[1:0];
  assign halted              = 1'b0;
  assign misalign_err_o      = 1'b0;
`endif

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_valid_i),
    .data_i  (q_in),
    .head_o  (q_head),
    .count_o (q_count_unused),
    .empty_o (q_empty),
    .full_o  (q_full)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; imem returns word index * 16.
// Build with FETCH_MISALIGN_CHECK_EN to check the misalign-halt variant.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic [4:0]  imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [31:0] pc;
  logic        misalign_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign imem_data = {23'd0, imem_addr, 4'd0};

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .ADDR_W   (5),
    .DEPTH    (2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .fetch_en_i       (fetch_en),
    .imem_addr_o      (imem_addr),
    .imem_data_i      (imem_data),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .out_valid_o      (out_valid),
    .out_ready_i      (out_ready),
    .out_pc_o         (out_pc),
    .out_instr_o      (out_instr),
    .pc_o             (pc),
    .misalign_err_o   (misalign_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    fetch_en       = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    #1;
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL reset_out_pc got=%h exp=0", out_pc); end
    checks++; if (out_instr !== 32'h0) begin failures++; $display("FAIL reset_out_instr got=%h exp=0", out_instr); end
    checks++; if (misalign_err !== 1'b0) begin failures++; $display("FAIL reset_misalign got=%b exp=0", misalign_err); end
    checks++; if (imem_addr !== 5'd0) begin failures++; $display("FAIL reset_imem_addr got=%0d exp=0", imem_addr); end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc [3];
    logic [31:0] exp_in [3];
    exp_pc = '{32'h0, 32'h4, 32'h8};
    exp_in = '{32'h00, 32'h10, 32'h20};
    do_reset();
    fetch_en  = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_no_bypass got=%b exp=0", out_valid); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== exp_pc[i] || out_instr !== exp_in[i]) begin
        failures++;
        $display("FAIL stream_%0d got v=%b pc=%h instr=%h exp v=1 pc=%h instr=%h",
                 i, out_valid, out_pc, out_instr, exp_pc[i], exp_in[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_pc [4];
    exp_pc = '{32'h4, 32'h8, 32'hC, 32'h10};
    do_reset();
    fetch_en  = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) step();
    checks++; if (pc !== 32'h8) begin failures++; $display("FAIL stall_pc_hold got=%h exp=%h", pc, 32'h8); end
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin failures++; $display("FAIL stall_head got v=%b pc=%h exp v=1 pc=0", out_valid, out_pc); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== exp_pc[i] || out_instr !== (exp_pc[i] << 2)) begin
        failures++;
        $display("FAIL stall_drain_%0d got v=%b pc=%h instr=%h exp pc=%h instr=%h",
                 i, out_valid, out_pc, out_instr, exp_pc[i], exp_pc[i] << 2);
      end
    end
  endtask

  task automatic test_fetch_en_drain();
    do_reset();
    fetch_en  = 1'b1;
    out_ready = 1'b0;
    step();
    step();
    fetch_en  = 1'b0;
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h4 || pc !== 32'h8) begin failures++; $display("FAIL drain_1 got v=%b out_pc=%h pc=%h exp v=1 out_pc=4 pc=8", out_valid, out_pc, pc); end
    step();
    checks++; if (out_valid !== 1'b0 || pc !== 32'h8) begin failures++; $display("FAIL drain_2 got v=%b pc=%h exp v=0 pc=8", out_valid, pc); end
  endtask

  task automatic test_redirect();
    do_reset();
    fetch_en  = 1'b1;
    out_ready = 1'b0;
    step();
    step();
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step();
    redirect_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL redirect_flush got=%b exp=0", out_valid); end
    checks++; if (pc !== 32'h40 || imem_addr !== 5'd16) begin failures++; $display("FAIL redirect_pc got pc=%h addr=%0d exp pc=40 addr=16", pc, imem_addr); end
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_instr !== 32'h100) begin failures++; $display("FAIL redirect_target got v=%b pc=%h instr=%h exp v=1 pc=40 instr=100", out_valid, out_pc, out_instr); end
    step();
    checks++; if (out_pc !== 32'h44 || out_instr !== 32'h110) begin failures++; $display("FAIL redirect_next got pc=%h instr=%h exp pc=44 instr=110", out_pc, out_instr); end
  endtask

  task automatic test_alias();
    do_reset();
    fetch_en       = 1'b1;
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h84;
    step();
    redirect_valid = 1'b0;
    #1;
    checks++; if (imem_addr !== 5'd1) begin failures++; $display("FAIL alias_addr got=%0d exp=1", imem_addr); end
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h84 || out_instr !== 32'h10) begin failures++; $display("FAIL alias_entry got v=%b pc=%h instr=%h exp v=1 pc=84 instr=10", out_valid, out_pc, out_instr); end
  endtask

  task automatic test_misalign();
    do_reset();
    fetch_en       = 1'b1;
    out_ready      = 1'b1;
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    step();
    redirect_valid = 1'b0;
    #1;
    checks++; if (pc !== 32'h40) begin failures++; $display("FAIL misalign_pc got=%h exp=40", pc); end
`ifdef FETCH_MISALIGN_CHECK_EN
    checks++; if (misalign_err !== 1'b1) begin failures++; $display("FAIL misalign_flag got=%b exp=1", misalign_err); end
    for (int i = 0; i < 3; i++) step();
    checks++; if (out_valid !== 1'b0 || pc !== 32'h40) begin failures++; $display("FAIL misalign_halt got v=%b pc=%h exp v=0 pc=40", out_valid, pc); end
    do_reset();
    checks++; if (misalign_err !== 1'b0) begin failures++; $display("FAIL misalign_clear got=%b exp=0", misalign_err); end
`else
    checks++; if (misalign_err !== 1'b0) begin failures++; $display("FAIL misalign_flag got=%b exp=0", misalign_err); end
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_instr !== 32'h100) begin failures++; $display("FAIL misalign_continue got v=%b pc=%h instr=%h exp v=1 pc=40 instr=100", out_valid, out_pc, out_instr); end
`endif
  endtask

  task automatic test_async_reset();
    do_reset();
    fetch_en  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    checks++; if (out_valid !== 1'b1 || pc !== 32'h10) begin failures++; $display("FAIL async_pre got v=%b pc=%h exp v=1 pc=10", out_valid, pc); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || pc !== 32'h0 || out_pc !== 32'h0) begin failures++; $display("FAIL async_reset got v=%b pc=%h out_pc=%h exp v=0 pc=0 out_pc=0", out_valid, pc, out_pc); end
    rst = 1'b0;
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin failures++; $display("FAIL async_restart got v=%b out_pc=%h exp v=1 out_pc=0", out_valid, out_pc); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_fetch_en_drain();
    test_redirect();
    test_alias();
    test_misalign();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
